mm_result_buf_sched: RTL

//  Ping-pong scheduler for the N banked result BRAMs of the matrix-multiply array.

---
 rtl/mm_buf_pkg.sv | 21 ++
 rtl/mm_result_buf_sched_if.sv | 40 ++++
 rtl/mm_skid_fifo.sv | 48 ++++
 rtl/mm_result_buf_sched.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mm_buf_pkg.sv
// Shared types and sizing helpers for the ping-pong result buffer scheduler.
// Words per bank per half and per-half address width are derived from M and N.
package mm_buf_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } rd_state_t;

    function automatic int unsigned buf_depth(input int unsigned m, input int unsigned n);
        return (m * m) / n;
    endfunction

    function automatic int unsigned buf_aw(input int unsigned m, input int unsigned n);
        int unsigned d;
        d = buf_depth(m, n);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/mm_result_buf_sched_if.sv
// Bundle of the PE write side, the banked BRAM ports and the result stream.
// master = environment (PE columns, BRAMs, stream sink); slave = scheduler.
interface mm_result_buf_sched_if
    import mm_buf_pkg::*;
#(
    parameter int unsigned D_W = 8,
    parameter int unsigned N   = 3,
    parameter int unsigned M   = 6
) ();

    localparam int unsigned AW = buf_aw(M, N);

    logic [N-1:0]          in_valid;
    logic [N-1:0][D_W-1:0] in_data;
    logic                  in_ready;
    logic [N-1:0]          wr_en_bram;
    logic [N-1:0][AW:0]    wr_addr_bram;
    logic [N-1:0][D_W-1:0] wr_data_bram;
    logic [N-1:0]          rd_en_bram;
    logic [AW:0]           rd_addr_bram;
    logic [N-1:0][D_W-1:0] rd_data_bram;
    logic                  out_valid;
    logic                  out_ready;
    logic [D_W-1:0]        out_data;
    logic                  out_last;
    logic                  overflow;

    modport master (
        output in_valid, in_data, rd_data_bram, out_ready,
        input  in_ready, wr_en_bram, wr_addr_bram, wr_data_bram,
        input  rd_en_bram, rd_addr_bram, out_valid, out_data, out_last, overflow
    );

    modport slave (
        input  in_valid, in_data, rd_data_bram, out_ready,
        output in_ready, wr_en_bram, wr_addr_bram, wr_data_bram,
        output rd_en_bram, rd_addr_bram, out_valid, out_data, out_last, overflow
    );

endinterface

// File: rtl/mm_skid_fifo.sv
// Two-entry FIFO with valid/ready on both sides; head data is held while stalled.
module mm_skid_fifo #(
    parameter int unsigned W = 9
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic [1:0][W-1:0] mem_q;
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;
    logic              push;
    logic              pop;

    always_comb begin
        in_ready_o  = (count_q != 2'd2);
        out_valid_o = (count_q != 2'd0);
        out_data_o  = mem_q[rd_ptr_q];
        push        = in_valid_i & in_ready_o;
        pop         = out_valid_o & out_ready_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/mm_result_buf_sched.sv
// Ping-pong scheduler for the banked result BRAMs: fills one half from the PE columns
// while draining the other, bank-interleaved and row-major, to a valid/ready stream.
module mm_result_buf_sched
    import mm_buf_pkg::*;
#(
    parameter int unsigned D_W = 8,
    parameter int unsigned N   = 3,
    parameter int unsigned M   = 6
) (
    input logic                  clk,
    input logic                  rst,
    mm_result_buf_sched_if.slave bus
);

    localparam int unsigned DEPTH = buf_depth(M, N);
    localparam int unsigned AW    = buf_aw(M, N);
    localparam int unsigned BW    = (N > 1) ? $clog2(N) : 1;

    // Write side
    logic       wr_buf_q;
    logic       rd_buf_q;
    logic [1:0] full_q;
    logic [1:0] full_d;
    logic       in_ready;
    logic       all_done;
    logic       overflow_q;
    logic [N-1:0] wr_en;
    logic [N-1:0] wrap;
    logic [N-1:0] done;

    // Read side
    rd_state_t   state_q;
    logic [AW-1:0] rd_elem_q;
    logic [BW-1:0] rd_bank_q;
    logic          inflight_q;
    logic [BW-1:0] infl_bank_q;
    logic          infl_last_q;
    logic          last_rd;
    logic          active;
    logic          room;
    logic          issue;
    logic          pop;
    logic          last_hs;
    logic [2:0]    occ;
    logic [1:0]    fifo_count;
    logic          fifo_in_ready;
    logic          fifo_valid;
    logic [D_W:0]  fifo_data;

    assign in_ready = ~full_q[wr_buf_q];
    // Same-cycle wraps count toward completion.
    assign all_done = &(done | wrap);

    for (genvar x = 0; x < N; x++) begin : g_wr
        logic [AW-1:0] cnt_q;
        logic          bank_done_q;

        assign wr_en[x] = bus.in_valid[x] & in_ready;
        assign wrap[x]  = wr_en[x] & (cnt_q == AW'(DEPTH - 1));
        assign done[x]  = bank_done_q;
        assign bus.wr_addr_bram[x] = {wr_buf_q, cnt_q};

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q       <= '0;
                bank_done_q <= 1'b0;
            end else begin
                if (wr_en[x]) begin
                    cnt_q <= wrap[x] ? '0 : cnt_q + 1'b1;
                end
                bank_done_q <= all_done ? 1'b0 : (bank_done_q | wrap[x]);
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.wr_en_bram   = wr_en;
    assign bus.wr_data_bram = bus.in_data;
    assign bus.overflow     = overflow_q;

    // Completion and drain always target different halves, so both may apply at once.
    always_comb begin
        full_d = full_q;
        if (all_done) begin
            full_d[wr_buf_q] = 1'b1;
        end
        if (last_hs) begin
            full_d[rd_buf_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q     <= 2'b00;
            wr_buf_q   <= 1'b0;
            rd_buf_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (all_done) begin
                wr_buf_q <= ~wr_buf_q;
            end
            if (last_hs) begin
                rd_buf_q <= ~rd_buf_q;
            end
            overflow_q <= overflow_q | (|(bus.in_valid & ~{N{in_ready}}));
        end
    end

    // Occupancy derived from the FIFO handshake flags: full, one entry, or empty.
    assign fifo_count = fifo_in_ready ? {1'b0, fifo_valid} : 2'd2;

    always_comb begin
        last_rd = (rd_elem_q == AW'(DEPTH - 1)) && (rd_bank_q == BW'(N - 1));
        active  = (state_q == StIssue) || ((state_q == StIdle) && full_q[rd_buf_q]);
        pop     = fifo_valid & bus.out_ready;
        occ     = 3'(fifo_count) + 3'(inflight_q);
        // A word leaving this cycle frees a slot, which keeps 1 word/cycle sustained.
        room    = occ < (3'd2 + 3'(pop));
        issue   = active & room;
        last_hs = pop & fifo_data[D_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rd_elem_q   <= '0;
            rd_bank_q   <= '0;
            inflight_q  <= 1'b0;
            infl_bank_q <= '0;
            infl_last_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                infl_bank_q <= rd_bank_q;
                infl_last_q <= last_rd;
                if (rd_bank_q == BW'(N - 1)) begin
                    rd_bank_q <= '0;
                    rd_elem_q <= last_rd ? '0 : rd_elem_q + 1'b1;
                end else begin
                    rd_bank_q <= rd_bank_q + 1'b1;
                end
            end
            unique case (state_q)
                StIdle:  if (full_q[rd_buf_q]) state_q <= StIssue;
                StIssue: if (issue && last_rd) state_q <= StDrain;
                StDrain: if (last_hs) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.rd_en_bram   = issue ? (N'(1) << rd_bank_q) : '0;
    assign bus.rd_addr_bram = {rd_buf_q, rd_elem_q};

    mm_skid_fifo #(
        .W (D_W + 1)
    ) u_skid (
        .clk_i       (clk),
        .rst_ni      (rst),
        .in_valid_i  (inflight_q),
        .in_data_i   ({infl_last_q, bus.rd_data_bram[infl_bank_q]}),
        .in_ready_o  (fifo_in_ready),
        .out_valid_o (fifo_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (fifo_data)
    );

    assign bus.out_valid = fifo_valid;
    assign bus.out_data  = fifo_data[D_W-1:0];
    assign bus.out_last  = fifo_data[D_W];

endmodule
